ether_debug_frame_capture: RTL

Parametrised single-frame GMII receive capture buffer for bring-up and debug, sitting directly on the PHY receive interface. Replaces the free-running byte logger with an armed capture. Once armed, it waits for the next clean frame start, optionally strips preamble/SFD, and stores exactly one frame (saturating at buffer depth). It reports length, overflow and completion, and exposes the stored bytes through a registered read port in the same clock domain.

---
 rtl/ether_debug_frame_capture.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ether_debug_frame_capture.sv
// ether_debug_frame_capture
//   Armed single-frame GMII receive capture buffer for bring-up/debug.
//   After `arm`, waits for the next clean frame start (dv rising edge),
//   optionally skips preamble through SFD, and stores one frame into a
//   DEPTH-entry buffer. Bytes beyond DEPTH are dropped and flagged.
//
// Ports
//   phy_rx_clk   sole clock (capture logic and read port)
//   rst_n        async active-low reset
//   phy_rx_dv    receive data valid
//   phy_rx_data  receive data byte
//   arm          one-cycle request to start a new capture (IDLE/DONE only)
//   abort        one-cycle request to return to IDLE (highest priority)
//   rd_addr      buffer read address
//   rd_data      registered read data, one cycle after rd_addr
//   busy         high in ARMED / SYNC / CAPTURE
//   done         high in DONE
//   overflow     frame was longer than DEPTH, excess dropped
//   frame_len    bytes stored, saturates at DEPTH
//   frame_count  completed captures, wraps at 2^16
module ether_debug_frame_capture #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 11,
  parameter bit STRIP_PREAMBLE = 1
) (
  input  logic              phy_rx_clk,
  input  logic              rst_n,
  input  logic              phy_rx_dv,
  input  logic [DATA_W-1:0] phy_rx_data,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   frame_len,
  output logic [15:0]       frame_count
);
  localparam int              DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] SFD = DATA_W'('hD5);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SYNC, S_CAPTURE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic              dv_q;
  logic              start;
  logic              wr_en, len_clr, ovf_set, cnt_inc;
  logic [DATA_W-1:0] mem [DEPTH];

  // A frame already in flight when armed never produces a start, because
  // dv_q tracks dv continuously regardless of state.
  assign start = phy_rx_dv && !dv_q;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    len_clr   = 1'b0;
    ovf_set   = 1'b0;
    cnt_inc   = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_nxt = S_ARMED;
            len_clr   = 1'b1;
          end
        end
        S_ARMED: begin
          if (start) begin
            if (STRIP_PREAMBLE) begin
              // The start byte itself may already be the SFD.
              state_nxt = (phy_rx_data == SFD) ? S_CAPTURE : S_SYNC;
            end else begin
              // frame_len is 0 here, so this lands at address 0.
              state_nxt = S_CAPTURE;
              wr_en     = 1'b1;
            end
          end
        end
        S_SYNC: begin
          if (!phy_rx_dv)                state_nxt = S_ARMED;
          else if (phy_rx_data == SFD)   state_nxt = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!phy_rx_dv) begin
            state_nxt = S_DONE;
            cnt_inc   = 1'b1;
          end else if (frame_len == FULL) begin
            ovf_set = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge phy_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dv_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      frame_len   <= '0;
      frame_count <= '0;
      rd_data     <= '0;
    end else begin
      state   <= state_nxt;
      dv_q    <= phy_rx_dv;
      busy    <= (state_nxt == S_ARMED) || (state_nxt == S_SYNC) ||
                 (state_nxt == S_CAPTURE);
      done    <= (state_nxt == S_DONE);
      rd_data <= mem[rd_addr];
      if (len_clr)    frame_len <= '0;
      else if (wr_en) frame_len <= frame_len + 1'b1;
      if (len_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      if (cnt_inc) frame_count <= frame_count + 16'd1;
    end
  end

  // Write pointer is frame_len itself; writes only occur below DEPTH so the
  // low bits never wrap onto address 0.
  always_ff @(posedge phy_rx_clk) begin
    if (wr_en) mem[frame_len[ADDR_W-1:0]] <= phy_rx_data;
  end

endmodule
